// File: rtl/seq_enable_chain_multi.sv
// ============================================================================
// seq_enable_chain_multi : per-channel counter (q) / capture (r) priority bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_enable_chain_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS*WIDTH-1:0] ld_val,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] r,
    output logic [CHANNELS-1:0]       r_valid,
    output logic [CHANNELS-1:0]       wrap
);

    localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("seq_enable_chain_multi: CHANNELS must be >= 1");
        end
        if (STEP < 1 || longint'(STEP) >= (longint'(1) << WIDTH)) begin : g_bad_step
            $error("seq_enable_chain_multi: STEP must be in 1 .. 2**WIDTH-1");
        end
    endgenerate

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] r_q;
            logic [WIDTH-1:0] r_r;
            logic             r_valid_q;
            logic             r_wrap;
            logic [WIDTH:0]   w_sum;

            // Carry bit of the widened sum is the overflow indication.
            assign w_sum = {1'b0, r_q} + c_step;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q       <= '0;
                    r_r       <= '0;
                    r_valid_q <= 1'b0;
                    r_wrap    <= 1'b0;
                end else if (ld[i]) begin
                    r_q    <= ld_val[i*WIDTH +: WIDTH];
                    r_wrap <= 1'b0;
                end else if (en[i]) begin
                    if (SATURATE != 0 && w_sum[WIDTH]) begin
                        r_q <= '1;
                    end else begin
                        r_q <= w_sum[WIDTH-1:0];
                    end
                    r_wrap <= w_sum[WIDTH];
                end else begin
                    r_r       <= d[i*WIDTH +: WIDTH];
                    r_valid_q <= 1'b1;
                    r_wrap    <= 1'b0;
                end
            end

            assign q[i*WIDTH +: WIDTH] = r_q;
            assign r[i*WIDTH +: WIDTH] = r_r;
            assign r_valid[i]          = r_valid_q;
            assign wrap[i]             = r_wrap;
        end
    endgenerate

endmodule

`default_nettype wire
